ladder_monitor: RTL and testbench

- Downstream consumer of the ladder counter's 4-bit count stream.
- Tracks the up/down ladder shape of the stream and reports each peak and valley.
- Counts completed ladders and flags illegal steps (|delta-count| > 1) and stalls.
- Provides runtime observability and self-check of the ladder counter in system and in test.

---
 rtl/ladder_pkg.sv | 22 ++
 rtl/ladder_sat_counter.sv | 32 +++
 rtl/ladder_monitor.sv | 170 +++++++++++++++++
 tb/tb_ladder_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ladder_pkg.sv
// rtl/ladder_pkg.sv - shared types, defaults and helpers for the ladder monitor
// Contents:
//   state_t     ladder shape tracker states (S_IDLE, S_UP, S_DOWN)
//   COUNT_W_DEF default width of the monitored count
//   sat_inc     increment that sticks at a given limit
package ladder_pkg;

   localparam int COUNT_W_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;

   // Returns value + 1, or value unchanged once it has reached limit.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] limit);
      return (value >= limit) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/ladder_sat_counter.sv
// rtl/ladder_sat_counter.sv - saturating event counter with synchronous clear
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   inc    count one event this cycle
//   clr    synchronous clear, wins over a same-cycle inc
//   q      current count, sticks at all-ones
module ladder_sat_counter
   import ladder_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   localparam logic [31:0] LIMIT = 32'((64'd1 << W) - 64'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= W'(sat_inc(32'(q), LIMIT));
      end
   end

endmodule

// File: rtl/ladder_monitor.sv
// rtl/ladder_monitor.sv - tracks the up/down ladder shape of a count stream
// Optional feature macro: LADDER_MON_MAXPEAK_EN (max_peak register; tied to 0 otherwise)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   count, sample_en      count sample and its evaluate strobe
//   clr                   synchronous clear of ladder_cnt, err_cnt, step_err, max_peak
//   peak, peak_valid      most recent peak height and its one-cycle update pulse
//   valley, valley_valid  most recent valley value and its one-cycle update pulse
//   ladder_cnt            completed ladders (peak then valley), saturating
//   step_err, err_cnt     sticky illegal-step flag and saturating illegal-step count
//   stalled               count unchanged for at least STALL_MAX samples
//   max_peak              largest peak seen
module ladder_monitor
   import ladder_pkg::*;
#(
   parameter int COUNT_W   = COUNT_W_DEF,
   parameter int LCNT_W    = 16,
   parameter int STALL_MAX = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COUNT_W-1:0] count,
   input  logic               sample_en,
   input  logic               clr,
   output logic [COUNT_W-1:0] peak,
   output logic               peak_valid,
   output logic [COUNT_W-1:0] valley,
   output logic               valley_valid,
   output logic [LCNT_W-1:0]  ladder_cnt,
   output logic               step_err,
   output logic [LCNT_W-1:0]  err_cnt,
   output logic               stalled,
   output logic [COUNT_W-1:0] max_peak
);

   localparam logic signed [COUNT_W:0] D_UP = {{COUNT_W{1'b0}}, 1'b1};
   localparam logic signed [COUNT_W:0] D_DN = '1;
   localparam logic [7:0]              STALL_LIM = 8'(STALL_MAX);

   state_t                   state_q, state_d;
   logic [COUNT_W-1:0]       prev_q;
   logic                     prev_vld;
   logic [7:0]               stall_q, stall_d;
   logic                     peak_seen;

   logic                     eval;
   logic signed [COUNT_W:0]  diff;
   logic                     is_up, is_dn, is_zero, big;
   logic                     peak_evt, valley_evt, err_evt;

   // The very first enabled sample only primes prev; evaluation starts after.
   assign eval    = sample_en & prev_vld;
   assign diff    = $signed({1'b0, count}) - $signed({1'b0, prev_q});
   assign is_up   = (diff == D_UP);
   assign is_dn   = (diff == D_DN);
   assign is_zero = (diff == '0);
   // Anything other than -1/0/+1 is illegal, including 15<->0 wrap steps.
   assign big     = ~(is_up | is_dn | is_zero);

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (eval) begin
         if (big) begin
            state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (is_up)      state_d = S_UP;
                  else if (is_dn) state_d = S_DOWN;
               end
               S_UP:    if (is_dn) state_d = S_DOWN;
               S_DOWN:  if (is_up) state_d = S_UP;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   // FSM: turning-point and error events
   always_comb begin
      peak_evt   = 1'b0;
      valley_evt = 1'b0;
      err_evt    = 1'b0;
      if (eval) begin
         err_evt    = big;
         peak_evt   = ~big & is_dn & (state_q == S_UP);
         valley_evt = ~big & is_up & (state_q == S_DOWN);
      end
   end

   // Equal-sample run length; frozen while sample_en is low.
   always_comb begin
      stall_d = stall_q;
      if (eval) begin
         stall_d = is_zero ? 8'(sat_inc(32'(stall_q), 32'(STALL_LIM))) : 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q       <= '0;
         prev_vld     <= 1'b0;
         stall_q      <= '0;
         stalled      <= 1'b0;
         peak         <= '0;
         peak_valid   <= 1'b0;
         valley       <= '0;
         valley_valid <= 1'b0;
         step_err     <= 1'b0;
         peak_seen    <= 1'b0;
      end else begin
         peak_valid   <= peak_evt;
         valley_valid <= valley_evt;
         if (peak_evt)   peak   <= prev_q;
         if (valley_evt) valley <= prev_q;
         if (sample_en) begin
            prev_q   <= count;
            prev_vld <= 1'b1;
         end
         stall_q <= stall_d;
         stalled <= (stall_d == STALL_LIM);
         if (clr)          step_err <= 1'b0;
         else if (err_evt) step_err <= 1'b1;
         // A ladder needs a peak between consecutive valleys.
         if (peak_evt)                peak_seen <= 1'b1;
         else if (clr || valley_evt)  peak_seen <= 1'b0;
      end
   end

   ladder_sat_counter #(.W(LCNT_W)) u_ladder_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (valley_evt & peak_seen),
      .clr   (clr),
      .q     (ladder_cnt)
   );

   ladder_sat_counter #(.W(LCNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_evt),
      .clr   (clr),
      .q     (err_cnt)
   );

`ifdef LADDER_MON_MAXPEAK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_peak <= '0;
      end else if (clr) begin
         max_peak <= '0;
      end else if (peak_evt && (prev_q > max_peak)) begin
         max_peak <= prev_q;
      end
   end
`else
   assign max_peak = '0;
`endif

endmodule

// File: tb/tb_ladder_monitor.sv
// tb/tb_ladder_monitor.sv - self-checking bench for ladder_monitor against a trend model
module tb_ladder_monitor;

   localparam int STALL = 8;
   localparam int CMAX  = 15;   // all-ones of the 4-bit counters under test

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] count = '0;
   logic       sample_en = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] peak, valley, ladder_cnt, err_cnt, max_peak;
   logic       peak_valid, valley_valid, step_err, stalled;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int m_have, m_prev, m_dir, m_run, m_seen;
   int m_peak, m_pv, m_valley, m_vv, m_lad, m_err, m_serr, m_stalled, m_max;

   always #5 clk = ~clk;

   ladder_monitor #(.COUNT_W(4), .LCNT_W(4), .STALL_MAX(STALL)) dut (
      .clk          (clk),
      .reset        (reset),
      .count        (count),
      .sample_en    (sample_en),
      .clr          (clr),
      .peak         (peak),
      .peak_valid   (peak_valid),
      .valley       (valley),
      .valley_valid (valley_valid),
      .ladder_cnt   (ladder_cnt),
      .step_err     (step_err),
      .err_cnt      (err_cnt),
      .stalled      (stalled),
      .max_peak     (max_peak)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_prev = 0; m_dir = 0; m_run = 0; m_seen = 0;
      m_peak = 0; m_pv = 0; m_valley = 0; m_vv = 0; m_lad = 0;
      m_err = 0; m_serr = 0; m_stalled = 0; m_max = 0;
   endtask

   // m_dir is the direction of the last legal nonzero step since reset or
   // the last illegal step: +1 rising, -1 falling, 0 unknown.
   task automatic model_step(input int c, input bit en, input bit cl);
      int d;
      bit pk, vl, er;
      pk = 0; vl = 0; er = 0;
      if (en) begin
         if (m_have != 0) begin
            d = c - m_prev;
            if (d > 1 || d < -1) begin
               er = 1;
               m_dir = 0;
            end else if (d == -1) begin
               if (m_dir == 1) begin pk = 1; m_peak = m_prev; end
               m_dir = -1;
            end else if (d == 1) begin
               if (m_dir == -1) begin vl = 1; m_valley = m_prev; end
               m_dir = 1;
            end
            if (d == 0) m_run = (m_run < STALL) ? m_run + 1 : m_run;
            else        m_run = 0;
         end
         m_have = 1;
         m_prev = c;
      end
      m_stalled = (m_run == STALL) ? 1 : 0;
      m_pv = pk;
      m_vv = vl;
      if (cl) m_lad = 0;
      else if (vl && m_seen != 0 && m_lad < CMAX) m_lad++;
      if (pk) m_seen = 1;
      else if (cl || vl) m_seen = 0;
      if (cl) m_err = 0;
      else if (er && m_err < CMAX) m_err++;
      if (cl) m_serr = 0;
      else if (er) m_serr = 1;
`ifdef LADDER_MON_MAXPEAK_EN
      if (cl) m_max = 0;
      else if (pk && m_peak > m_max) m_max = m_peak;
`endif
   endtask

   task automatic check_all();
      check("peak", peak, m_peak);
      check("peak_valid", peak_valid, m_pv);
      check("valley", valley, m_valley);
      check("valley_valid", valley_valid, m_vv);
      check("ladder_cnt", ladder_cnt, m_lad);
      check("step_err", step_err, m_serr);
      check("err_cnt", err_cnt, m_err);
      check("stalled", stalled, m_stalled);
      check("max_peak", max_peak, m_max);
   endtask

   task automatic step(input int c, input bit en, input bit cl);
      count = 4'(c);
      sample_en = en;
      clr = cl;
      @(posedge clk);
      #1;
      model_step(c, en, cl);
      check_all();
   endtask

   task automatic do_reset();
      sample_en = 1'b0;
      clr = 1'b0;
      reset = 1'b1;
      #2;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   int seq1 [11] = '{0, 1, 2, 3, 2, 1, 2, 3, 2, 1, 2};
   int seq2 [8]  = '{1, 2, 3, 5, 4, 3, 2, 3};
   int seq3 [7]  = '{0, 3, 4, 5, 4, 3, 4};
   int seq4 [14] = '{0, 1, 2, 3, 2, 3, 4, 5, 4, 3, 2, 1, 2, 1};
   int seq5 [6]  = '{0, 1, 2, 1, 0, 1};
   int npk, nvl, cur, nx, r, exp_max;
   bit en, cl;

   initial begin
      model_reset();

      // Basic ladder: two peaks at 3, two valleys at 1.
      do_reset();
      npk = 0; nvl = 0;
      foreach (seq1[i]) begin
         step(seq1[i], 1'b1, 1'b0);
         if (peak_valid === 1'b1) begin npk++; check("t1_peak_val", peak, 3); end
         if (valley_valid === 1'b1) begin nvl++; check("t1_valley_val", valley, 1); end
      end
      check("t1_peak_pulses", npk, 2);
      check("t1_valley_pulses", nvl, 2);
      check("t1_ladder_cnt", ladder_cnt, 2);
      check("t1_step_err", step_err, 0);

      // Illegal step resets the shape; 4,3,2 falls from idle, 3 turns up.
      do_reset();
      npk = 0;
      foreach (seq2[i]) begin
         step(seq2[i], 1'b1, 1'b0);
         if (i == 3) begin
            check("t2_step_err", step_err, 1);
            check("t2_err_cnt", err_cnt, 1);
         end
         if (i >= 4 && peak_valid === 1'b1) npk++;
      end
      check("t2_no_peak", npk, 0);
      check("t2_valley_after_3", valley_valid, 1);
      check("t2_no_ladder", ladder_cnt, 0);

      // Stall: 1 loaded, then nine equal samples.
      do_reset();
      step(1, 1'b1, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         step(1, 1'b1, 1'b0);
         check("t3_stalled", stalled, (k >= STALL) ? 1 : 0);
      end
      step(2, 1'b1, 1'b0);
      check("t3_unstall", stalled, 0);

      // clr on the valley cycle: pulse survives, counters and flag clear.
      do_reset();
      foreach (seq3[i]) begin
         step(seq3[i], 1'b1, (i == 6) ? 1'b1 : 1'b0);
         if (i == 5) begin
            check("t4_pre_step_err", step_err, 1);
            check("t4_pre_err_cnt", err_cnt, 1);
         end
      end
      check("t4_valley_valid", valley_valid, 1);
      check("t4_valley", valley, 3);
      check("t4_ladder_cnt", ladder_cnt, 0);
      check("t4_step_err", step_err, 0);

      // err_cnt saturation: 17 wrap steps.
      do_reset();
      for (int k = 0; k < 18; k++) step((k % 2 == 1) ? 15 : 0, 1'b1, 1'b0);
      check("t5_err_sat", err_cnt, 15);

      // Peaks 3, 5, 2.
      do_reset();
      foreach (seq4[i]) step(seq4[i], 1'b1, 1'b0);
`ifdef LADDER_MON_MAXPEAK_EN
      exp_max = 5;
`else
      exp_max = 0;
`endif
      check("t6_max_peak", max_peak, exp_max);

      // Asynchronous reset between edges.
      do_reset();
      foreach (seq5[i]) step(seq5[i], 1'b1, 1'b0);
      check("t7_pre_ladder", ladder_cnt, 1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("t7_async_ladder", ladder_cnt, 0);
      @(negedge clk);
      reset = 1'b0;

      // Random walk with gaps, jumps and occasional clears.
      do_reset();
      cur = 8;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         nx = cur;
         if (r < 3)       nx = cur + 1;
         else if (r < 6)  nx = cur - 1;
         else if (r == 9) nx = $urandom_range(0, 15);
         if (nx > 15) nx = 14;
         if (nx < 0)  nx = 1;
         en = ($urandom_range(0, 9) != 0);
         cl = en && ($urandom_range(0, 29) == 0);
         step(nx, en, cl);
         if (en) cur = nx;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
